// File: rtl/recip_nr.sv
// Newton-Raphson reciprocal on a range-reduced operand, with the scaler shift undone on the result.
// One operation in flight; a single multiplier is time-shared between the t and y update steps.
//
// state | meaning
// IDLE  | waiting for start_i, outputs hold last result
// MUL_T | t = x * y
// MUL_Y | y = (y * (2^(F+1) - t)) >> F, count iteration
// SCALE | undo range reduction, register y_o/err_o, pulse done_o
module recip_nr #(
  parameter int W    = 8,
  parameter int F    = 16,
  parameter int ITER = 3,
  parameter int SEED = 4096,
  parameter int XMIN = 12,
  parameter int XMAX = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] x_scaled_i,
  input  logic         shift_l_i,
  input  logic         shift_r_i,
  input  logic         no_shift_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [F-1:0] y_o,
  output logic         err_o
);

  localparam int CW = $clog2(ITER + 1);
  localparam int PW = 2 * F + 2;
  localparam logic [W+F-1:0] TWO_F1 = (W + F)'(1) << (F + 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL_T,
    MUL_Y,
    SCALE
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]   x_q;
  logic [F-1:0]   y_q;
  logic [W+F-1:0] t_q;
  logic [CW-1:0]  cnt_q;
  logic           sl_q, sr_q, ns_q, err_q;

  logic [F+1:0]   d_val;
  logic [F+1:0]   mul_b;
  logic [PW-1:0]  prod;
  logic [F-1:0]   y_next;
  logic [F-1:0]   y_scaled;
  logic [CW-1:0]  cnt_inc;
  logic           op_err;

  // d goes negative once t exceeds 2^(F+1); clamp it there rather than wrap
  always_comb begin
    d_val = '0;
    if (t_q < TWO_F1) d_val = TWO_F1[F+1:0] - t_q[F+1:0];
  end

  always_comb begin
    mul_b = d_val;
    if (state_q == MUL_T) mul_b = (F + 2)'(x_q);
    prod = PW'(y_q) * PW'(mul_b);
  end

  always_comb begin
    y_next = prod[2*F-1:F];
    if (prod[PW-1:2*F] != '0) y_next = '1;
  end

  always_comb begin
    y_scaled = y_q;
    if (sr_q) begin
      y_scaled = {1'b0, y_q[F-1:1]};
    end else if (sl_q) begin
      y_scaled = y_q[F-1] ? '1 : {y_q[F-2:0], 1'b0};
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  assign op_err = (x_scaled_i < W'(XMIN)) || (x_scaled_i > W'(XMAX)) ||
                  !$onehot({shift_l_i, shift_r_i, no_shift_i});

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = MUL_T;
      MUL_T:   state_d = MUL_Y;
      MUL_Y:   state_d = (cnt_inc == CW'(ITER)) ? SCALE : MUL_T;
      SCALE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      t_q     <= '0;
      cnt_q   <= '0;
      sl_q    <= 1'b0;
      sr_q    <= 1'b0;
      ns_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      y_o     <= '0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_o  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            x_q    <= x_scaled_i;
            sl_q   <= shift_l_i;
            sr_q   <= shift_r_i;
            ns_q   <= no_shift_i;
            y_q    <= F'(SEED);
            cnt_q  <= '0;
            err_q  <= op_err;
            busy_o <= 1'b1;
          end
        end
        MUL_T: t_q <= prod[W+F-1:0];
        MUL_Y: begin
          y_q   <= y_next;
          cnt_q <= cnt_inc;
        end
        SCALE: begin
          y_o    <= err_q ? '0 : y_scaled;
          err_o  <= err_q;
          done_o <= 1'b1;
          busy_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // ns_q is kept for completeness of the latched operand; the scale mux only needs sl/sr
  logic unused_ok;
  assign unused_ok = ns_q;

endmodule

// File: tb/tb_recip_nr.sv
// Randomized self-checking bench for recip_nr: reference model computes 1/x_orig directly
// and checks latency, handshake, error handling, back-to-back start and mid-operation reset.
module tb_recip_nr;
  localparam int W = 8;
  localparam int F = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [W-1:0] x_scaled_i;
  logic         shift_l_i, shift_r_i, no_shift_i;
  logic         busy_o, done_o, err_o;
  logic [F-1:0] y_o;

  int n_checks = 0;
  int n_errors = 0;

  recip_nr dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .x_scaled_i(x_scaled_i),
    .shift_l_i (shift_l_i),
    .shift_r_i (shift_r_i),
    .no_shift_i(no_shift_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .y_o       (y_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ideal result: error if out of range or flags not one-hot, else floor(2^F / x_orig)
  function automatic void model(input int x, input int sl, input int sr, input int ns,
                                output bit e, output int ideal);
    e = (x < 12) || (x > 20) || ((sl + sr + ns) != 1);
    if (x == 0) ideal = 0;
    else if (sl != 0) ideal = (1 << (F + 1)) / x;
    else if (sr != 0) ideal = (1 << (F - 1)) / x;
    else ideal = (1 << F) / x;
    if (ideal > (1 << F) - 1) ideal = (1 << F) - 1;
  endfunction

  task automatic run_op(input int x, input int sl, input int sr, input int ns,
                        output int y, output int e, output int lat);
    @(negedge clk);
    x_scaled_i = W'(x);
    shift_l_i  = sl[0];
    shift_r_i  = sr[0];
    no_shift_i = ns[0];
    start_i    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i    = 1'b0;
    x_scaled_i = W'($urandom_range(0, 255));
    shift_l_i  = 1'($urandom_range(0, 1));
    shift_r_i  = 1'($urandom_range(0, 1));
    no_shift_i = 1'($urandom_range(0, 1));
    check("busy_after_start", busy_o, 1);
    lat = 0;
    while (!done_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    y = int'(y_o);
    e = int'(err_o);
    check("busy_in_done", busy_o, 0);
    @(negedge clk);
    check("done_width", done_o, 0);
  endtask

  task automatic op_check(input string tag, input int x, input int sl, input int sr,
                          input int ns, input int exact);
    int y, e, lat, ideal, diff;
    bit me;
    model(x, sl, sr, ns, me, ideal);
    run_op(x, sl, sr, ns, y, e, lat);
    check({tag, "_lat"}, lat, 7);
    check({tag, "_err"}, e, me);
    if (me) begin
      check({tag, "_y0"}, y, 0);
    end else if (exact >= 0) begin
      check({tag, "_y"}, y, exact);
    end else begin
      diff = y - ideal;
      if (diff < 0) diff = -diff;
      if (diff > 2) $display("  %s: y=%0d ideal=%0d", tag, y, ideal);
      check({tag, "_acc"}, (diff <= 2) ? 1 : 0, 1);
    end
  endtask

  initial begin
    int dones, first_c, second_c, y2, d2, sel, fl;
    rst = 1'b1;
    start_i = 1'b0;
    x_scaled_i = '0;
    shift_l_i = 1'b0;
    shift_r_i = 1'b0;
    no_shift_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_busy", busy_o, 0);
      check("idle_done", done_o, 0);
      check("idle_y", y_o, 0);
      check("idle_err", err_o, 0);
    end

    op_check("x16_ns", 16, 0, 0, 1, 4096);
    op_check("x16_sr", 16, 0, 1, 0, 2048);
    op_check("x16_sl", 16, 1, 0, 0, 8192);

    op_check("x12_sl", 12, 1, 0, 0, -1);
    op_check("x20_sr", 20, 0, 1, 0, -1);
    op_check("x13_ns", 13, 0, 0, 1, -1);

    op_check("x25_ns", 25, 0, 0, 1, -1);
    op_check("x10_sr", 10, 0, 1, 0, -1);
    op_check("x16_slsr", 16, 1, 1, 0, -1);
    op_check("x16_recover", 16, 0, 0, 1, 4096);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        fl = int'($urandom_range(0, 7));
        op_check("rand_any", int'($urandom_range(0, 255)), (fl >> 2) & 1, (fl >> 1) & 1,
                 fl & 1, -1);
      end else begin
        sel = int'($urandom_range(0, 2));
        op_check("rand_legal", int'($urandom_range(12, 20)), (sel == 0) ? 1 : 0,
                 (sel == 1) ? 1 : 0, (sel == 2) ? 1 : 0, -1);
      end
    end

    // start held high: second op accepted at the edge ending the first done cycle
    @(negedge clk);
    x_scaled_i = 8'd16;
    shift_l_i = 1'b0;
    shift_r_i = 1'b0;
    no_shift_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk);
    dones = 0;
    first_c = -1;
    second_c = -1;
    y2 = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o) begin
        dones++;
        if (dones == 1) begin
          first_c = c;
          check("b2b_y1", y_o, 4096);
          check("b2b_err1", err_o, 0);
          check("b2b_busy1", busy_o, 0);
          x_scaled_i = 8'd13;
          shift_l_i = 1'b0;
          shift_r_i = 1'b0;
          no_shift_i = 1'b1;
        end else if (dones == 2) begin
          second_c = c;
          y2 = int'(y_o);
          check("b2b_err2", err_o, 0);
          start_i = 1'b0;
        end
      end else if (start_i) begin
        x_scaled_i = W'($urandom_range(0, 255));
        shift_l_i = 1'($urandom_range(0, 1));
        shift_r_i = 1'($urandom_range(0, 1));
        no_shift_i = 1'($urandom_range(0, 1));
      end
    end
    start_i = 1'b0;
    check("b2b_count", dones, 2);
    check("b2b_t1", first_c, 7);
    check("b2b_t2", second_c, 15);
    d2 = y2 - 5041;
    if (d2 < 0) d2 = -d2;
    check("b2b_y2_acc", (d2 <= 2) ? 1 : 0, 1);

    // reset three cycles into an operation
    @(negedge clk);
    x_scaled_i = 8'd16;
    shift_l_i = 1'b0;
    shift_r_i = 1'b0;
    no_shift_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_y", y_o, 0);
    check("rst_err", err_o, 0);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done_o) dones++;
    end
    check("rst_no_done", dones, 0);
    check("rst_y_held", y_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
